// File: rtl/hififo_fpc_reorder_if.sv
// ---------------------------------------------------------------------------
// hififo_fpc_reorder_if
//   Bundles the three streams of the from-PC reorder stage:
//     rc_*  : read completions arriving from the PCIe RX demux
//     rr_*  : read requests going out to the TX arbiter
//     o_*   : in-order data stream going to the user-side FIFO / CDC
//   modport slave  : the reorder stage's view
//   modport master : the surrounding system's view
// ---------------------------------------------------------------------------
interface hififo_fpc_reorder_if #(
    parameter int DBITS = 64,
    parameter int SBITS = 3,
    parameter int IBITS = 6
);
    // Completion stream
    logic             rc_valid;
    logic [7:0]       rc_tag;
    logic [IBITS-1:0] rc_index;
    logic [DBITS-1:0] rc_data;

    // Read-request handshake
    logic             rr_valid;
    logic [SBITS-1:0] rr_tag_low;
    logic             rr_ready;

    // Output stream
    logic [DBITS-1:0] o_data;
    logic             o_valid;
    logic             o_ready;

    modport slave (
        input  rc_valid, rc_tag, rc_index, rc_data,
        input  rr_ready,
        input  o_ready,
        output rr_valid, rr_tag_low,
        output o_data, o_valid
    );

    modport master (
        output rc_valid, rc_tag, rc_index, rc_data,
        output rr_ready,
        output o_ready,
        input  rr_valid, rr_tag_low,
        input  o_data, o_valid
    );
endinterface

// File: rtl/hififo_fpc_reorder.sv
// ---------------------------------------------------------------------------
// hififo_fpc_reorder
//   Issues read-request tags, accepts out-of-order completions into a
//   slot-indexed block RAM and releases whole blocks in request order as a
//   valid/ready stream.
//
// Ports
//   clock, reset     single clock, asynchronous active-low reset
//   fifo_number      channel ID matched against rc_tag[7:4]
//   enable           permits new read requests
//   request_limit    blocks to fetch in this transfer (0 = none)
//   bus              completion / request / output streams (slave modport)
//   delivered        blocks fully delivered on the output
//   done             delivered == request_limit, request_limit != 0
//   error            sticky: bad last beat (slot not outstanding or refilled)
// ---------------------------------------------------------------------------
module hififo_fpc_reorder #(
    parameter int DBITS   = 64,
    parameter int SBITS   = 3,
    parameter int IBITS   = 6,
    parameter int MAX_OUT = 6,
    parameter int HOLDOFF = 3,
    parameter int CBITS   = 24
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          fifo_number,
    input  logic                enable,
    input  logic [CBITS-1:0]    request_limit,
    hififo_fpc_reorder_if.slave bus,
    output logic [CBITS-1:0]    delivered,
    output logic                done,
    output logic                error
);
    localparam int NSLOT = 1 << SBITS;
    localparam int ABITS = SBITS + IBITS;
    localparam int HBITS = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    localparam logic [SBITS-1:0] MAX_OUT_S = SBITS'(MAX_OUT);
    localparam logic [HBITS-1:0] HOLDOFF_H = HBITS'(HOLDOFF);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [SBITS-1:0] p_req_q, p_req_d;     // next slot to request
    logic [SBITS-1:0] p_rel_q, p_rel_d;     // oldest slot not yet released
    logic [SBITS-1:0] p_blk_q, p_blk_d;     // first slot not yet known filled
    logic [ABITS-1:0] p_rd_q,  p_rd_d;      // {slot, beat} read pointer
    logic [NSLOT-1:0] filled_q, filled_d;
    logic [HBITS-1:0] hold_q, hold_d;
    logic [CBITS-1:0] requested_q, requested_d;
    logic [CBITS-1:0] delivered_q, delivered_d;
    logic             error_q, error_d;

    // Read pipeline and 2-entry output buffer
    logic             rd_v_q;
    logic             rd_last_q;
    logic [DBITS-1:0] rd_data_q;
    logic [DBITS-1:0] buf_data_q [2];
    logic             buf_last_q [2];
    logic             buf_wp_q, buf_rp_q;
    logic [1:0]       buf_cnt_q, buf_cnt_d;

    // -----------------------------------------------------------------------
    // Write path
    // -----------------------------------------------------------------------
    logic             wr_hit;
    logic             wr_last;
    logic [SBITS-1:0] wr_slot;
    logic [SBITS-1:0] outstanding;
    logic [SBITS-1:0] slot_off;
    logic             slot_ok;
    logic             bad_last;
    logic             good_last;
    logic             unused_tag;

    assign wr_hit   = bus.rc_valid && (bus.rc_tag[7:4] == fifo_number);
    assign wr_slot  = bus.rc_tag[SBITS-1:0];
    assign wr_last  = wr_hit && (&bus.rc_index);

    // Modular distance from p_rel tells whether a slot lies in [p_rel, p_req).
    assign outstanding = p_req_q - p_rel_q;
    assign slot_off    = wr_slot - p_rel_q;
    assign slot_ok     = slot_off < outstanding;
    assign bad_last    = wr_last && (filled_q[wr_slot] || !slot_ok);
    // A bad last beat still writes data but never marks the slot filled, so a
    // stray completion cannot make the retire side emit a phantom block.
    assign good_last   = wr_last && !bad_last;

    assign unused_tag  = ^bus.rc_tag;

    logic [DBITS-1:0] ram_q [1 << ABITS];

    // NOTE: the block RAM has no reset; slot flags guard every read, and a
    // reset port would stop the array mapping onto RAM primitives.
    always_ff @(posedge clock) begin
        if (wr_hit) begin
            ram_q[{wr_slot, bus.rc_index}] <= bus.rc_data;
        end
    end

    // -----------------------------------------------------------------------
    // Request path
    // -----------------------------------------------------------------------
    logic req_acc;

    assign bus.rr_valid   = enable && (hold_q == '0) && (outstanding < MAX_OUT_S)
                            && (requested_q < request_limit);
    assign bus.rr_tag_low = p_req_q;
    assign req_acc        = bus.rr_valid && bus.rr_ready;

    // -----------------------------------------------------------------------
    // Retire path
    // -----------------------------------------------------------------------
    logic [SBITS-1:0] rd_top;
    logic [1:0]       occ;
    logic             pop;
    logic             rd_en;
    logic             rd_last;
    logic             blk_adv;

    assign rd_top  = p_rd_q[ABITS-1:IBITS];
    assign pop     = (buf_cnt_q != 2'd0) && bus.o_ready;
    // Occupancy counts beats in the buffer plus the one in flight out of the
    // RAM, net of this cycle's pop; a read is launched only if it will fit.
    assign occ     = buf_cnt_q + {1'b0, rd_v_q} - {1'b0, pop};
    assign rd_en   = (rd_top != p_blk_q) && (occ < 2'd2);
    assign rd_last = rd_en && (&p_rd_q[IBITS-1:0]);
    assign blk_adv = filled_q[p_blk_q] && (p_blk_q != p_req_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets its default first so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        p_req_d     = p_req_q;
        p_rel_d     = p_rel_q;
        p_blk_d     = p_blk_q;
        p_rd_d      = p_rd_q;
        filled_d    = filled_q;
        hold_d      = hold_q;
        requested_d = requested_q;
        delivered_d = delivered_q;
        error_d     = error_q;
        buf_cnt_d   = buf_cnt_q;

        if (req_acc) begin
            p_req_d     = p_req_q + 1'b1;
            requested_d = requested_q + 1'b1;
            hold_d      = HOLDOFF_H;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        if (blk_adv) begin
            p_blk_d = p_blk_q + 1'b1;
        end

        if (rd_en) begin
            p_rd_d = p_rd_q + 1'b1;
        end

        // Clear before set so a same-cycle set on the same slot wins.
        if (rd_last) begin
            filled_d[rd_top] = 1'b0;
            p_rel_d          = p_rel_q + 1'b1;
        end
        if (good_last) begin
            filled_d[wr_slot] = 1'b1;
        end

        if (bad_last) begin
            error_d = 1'b1;
        end

        if (pop && buf_last_q[buf_rp_q] && (delivered_q < request_limit)) begin
            delivered_d = delivered_q + 1'b1;
        end

        buf_cnt_d = buf_cnt_q + {1'b0, rd_v_q} - {1'b0, pop};
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_req_q     <= '0;
            p_rel_q     <= '0;
            p_blk_q     <= '0;
            p_rd_q      <= '0;
            filled_q    <= '0;
            hold_q      <= '0;
            requested_q <= '0;
            delivered_q <= '0;
            error_q     <= 1'b0;
            rd_v_q      <= 1'b0;
            buf_wp_q    <= 1'b0;
            buf_rp_q    <= 1'b0;
            buf_cnt_q   <= 2'd0;
        end else begin
            p_req_q     <= p_req_d;
            p_rel_q     <= p_rel_d;
            p_blk_q     <= p_blk_d;
            p_rd_q      <= p_rd_d;
            filled_q    <= filled_d;
            hold_q      <= hold_d;
            requested_q <= requested_d;
            delivered_q <= delivered_d;
            error_q     <= error_d;
            rd_v_q      <= rd_en;
            buf_cnt_q   <= buf_cnt_d;
            if (rd_v_q) begin
                buf_wp_q <= ~buf_wp_q;
            end
            if (pop) begin
                buf_rp_q <= ~buf_rp_q;
            end
        end
    end

    // Datapath payload; qualified by rd_v_q / buf_cnt_q, so no reset needed.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data_q <= ram_q[p_rd_q];
            rd_last_q <= rd_last;
        end
        if (rd_v_q) begin
            buf_data_q[buf_wp_q] <= rd_data_q;
            buf_last_q[buf_wp_q] <= rd_last_q;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.o_valid = (buf_cnt_q != 2'd0);
    assign bus.o_data  = buf_data_q[buf_rp_q];
    assign delivered   = delivered_q;
    assign done        = (delivered_q == request_limit) && (request_limit != '0);
    assign error       = error_q;
endmodule

// File: tb/tb_hififo_fpc_reorder.sv
// ---------------------------------------------------------------------------
// tb_hififo_fpc_reorder
//   Directed bench for the reorder stage. Inputs change 1 time unit after
//   the rising edge; outputs are sampled on the falling edge. Block number k
//   carries the pattern pat(k, beat), so the in-order output stream is
//   predicted purely from the count of beats seen.
// ---------------------------------------------------------------------------
module tb_hififo_fpc_reorder;
    localparam int DBITS   = 64;
    localparam int SBITS   = 3;
    localparam int IBITS   = 6;
    localparam int MAX_OUT = 6;
    localparam int HOLDOFF = 3;
    localparam int CBITS   = 24;
    localparam int BEATS   = 1 << IBITS;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       fifo_number = 4'h5;
    logic             enable = 1'b0;
    logic [CBITS-1:0] request_limit = '0;
    logic [CBITS-1:0] delivered;
    logic             done;
    logic             error;

    hififo_fpc_reorder_if #(.DBITS(DBITS), .SBITS(SBITS), .IBITS(IBITS)) bus ();

    hififo_fpc_reorder #(
        .DBITS(DBITS), .SBITS(SBITS), .IBITS(IBITS),
        .MAX_OUT(MAX_OUT), .HOLDOFF(HOLDOFF), .CBITS(CBITS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fifo_number   (fifo_number),
        .enable        (enable),
        .request_limit (request_limit),
        .bus           (bus),
        .delivered     (delivered),
        .done          (done),
        .error         (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DBITS-1:0] pat(input int blk, input int idx);
        pat = {16'hC0DE, 16'(blk), 16'hF00D, 16'(idx)};
    endfunction

    // Cycle counter
    int cyc = 0;
    always @(posedge clock) cyc++;

    // o_ready pattern: 0 = low, 1 = high, 2 = toggle every cycle
    int oready_mode = 1;
    always @(posedge clock) begin
        #1;
        case (oready_mode)
            0:       bus.o_ready = 1'b0;
            1:       bus.o_ready = 1'b1;
            default: bus.o_ready = ~bus.o_ready;
        endcase
    end

    // Monitor: output scoreboard and request log, cleared while in reset
    int beats = 0;
    int data_errs = 0;
    int first_x = 0;
    int last_x = 0;
    int req_count = 0;
    int req_tag [16];
    int req_cyc [16];

    always @(negedge clock) begin
        if (!reset) begin
            beats     = 0;
            data_errs = 0;
            first_x   = 0;
            last_x    = 0;
            req_count = 0;
        end else begin
            if (bus.o_valid && bus.o_ready) begin
                if (bus.o_data !== pat(beats >> IBITS, beats % BEATS)) data_errs++;
                if (beats == 0) first_x = cyc;
                last_x = cyc;
                beats++;
            end
            if (bus.rr_valid && bus.rr_ready) begin
                if (req_count < 16) begin
                    req_tag[req_count] = int'(bus.rr_tag_low);
                    req_cyc[req_count] = cyc;
                end
                req_count++;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic reset_dut(input logic [CBITS-1:0] lim);
        reset = 1'b0;
        enable = 1'b0;
        bus.rc_valid = 1'b0;
        request_limit = lim;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        enable = 1'b1;
    endtask

    task automatic drive_beat(input logic [3:0] chan, input int slot, input int idx,
                              input logic [DBITS-1:0] d);
        @(posedge clock);
        #1;
        bus.rc_valid = 1'b1;
        bus.rc_tag   = {chan, 4'(slot)};
        bus.rc_index = IBITS'(idx);
        bus.rc_data  = d;
    endtask

    task automatic drive_idle();
        @(posedge clock);
        #1;
        bus.rc_valid = 1'b0;
    endtask

    task automatic send_block(input int blk);
        for (int i = 0; i < BEATS; i++) drive_beat(fifo_number, blk % 8, i, pat(blk, i));
        drive_idle();
    endtask

    task automatic send_pair(input int a, input int b);
        for (int i = 0; i < BEATS; i++) begin
            drive_beat(fifo_number, a % 8, i, pat(a, i));
            drive_beat(fifo_number, b % 8, i, pat(b, i));
        end
        drive_idle();
    endtask

    task automatic wait_reqs(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && req_count < n; i++) @(posedge clock);
        @(negedge clock);
        check(tag, req_count, n);
    endtask

    task automatic wait_delivered(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && int'(delivered) < n; i++) @(posedge clock);
        @(negedge clock);
        check(tag, delivered, n);
    endtask

    task automatic wait_ovalid(input string tag, input int budget);
        for (int i = 0; i < budget && !bus.o_valid; i++) @(posedge clock);
        @(negedge clock);
        check(tag, bus.o_valid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    initial begin
        bus.rc_valid = 1'b0;
        bus.rc_tag   = '0;
        bus.rc_index = '0;
        bus.rc_data  = '0;
        bus.rr_ready = 1'b1;
        bus.o_ready  = 1'b1;

        // Reset state
        reset_dut(0);
        @(negedge clock);
        check("rst_rr_valid", bus.rr_valid, 0);
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_delivered", delivered, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);

        // 1: four blocks in tag order
        reset_dut(4);
        wait_reqs("t1_reqs", 4, 100);
        for (int k = 0; k < 4; k++) check("t1_tag", req_tag[k], k);
        for (int k = 0; k < 4; k++) send_block(k);
        wait_delivered("t1_delivered", 4, 500);
        repeat (20) @(posedge clock);
        @(negedge clock);
        check("t1_beats", beats, 4 * BEATS);
        check("t1_data", data_errs, 0);
        check("t1_done", done, 1);
        check("t1_no_more_req", req_count, 4);
        check("t1_rr_idle", bus.rr_valid, 0);

        // 2: completions out of order and interleaved
        reset_dut(8);
        wait_reqs("t2_reqs6", MAX_OUT, 100);
        send_pair(3, 1);
        send_pair(0, 2);
        wait_delivered("t2_first4", 4, 800);
        check("t2_beats4", beats, 4 * BEATS);
        check("t2_data4", data_errs, 0);
        send_block(4);
        send_block(5);
        wait_reqs("t2_reqs8", 8, 600);
        send_block(6);
        send_block(7);
        wait_delivered("t2_delivered", 8, 800);
        @(negedge clock);
        check("t2_beats", beats, 8 * BEATS);
        check("t2_data", data_errs, 0);
        check("t2_done", done, 1);

        // 3: no completions -> outstanding limit and holdoff spacing
        reset_dut(100);
        repeat (60) @(posedge clock);
        @(negedge clock);
        check("t3_req_count", req_count, MAX_OUT);
        check("t3_spacing", req_cyc[1] - req_cyc[0], HOLDOFF + 1);
        check("t3_span", req_cyc[MAX_OUT-1] - req_cyc[0], (MAX_OUT - 1) * (HOLDOFF + 1));
        check("t3_rr_blocked", bus.rr_valid, 0);
        send_block(0);
        wait_reqs("t3_req_after_drain", MAX_OUT + 1, 300);
        wait_delivered("t3_delivered", 1, 300);

        // 4: o_ready toggling, three blocks
        reset_dut(3);
        oready_mode = 2;
        wait_reqs("t4_reqs", 3, 100);
        for (int k = 0; k < 3; k++) send_block(k);
        wait_delivered("t4_delivered", 3, 1000);
        check("t4_beats", beats, 3 * BEATS);
        check("t4_data", data_errs, 0);
        check("t4_rate", last_x - first_x, 2 * (3 * BEATS - 1));
        oready_mode = 1;

        // 5a: duplicate last beat for slot 2
        reset_dut(4);
        wait_reqs("t5_reqs", 4, 100);
        send_block(0);
        send_block(1);
        send_block(2);
        drive_beat(fifo_number, 2, BEATS - 1, pat(2, BEATS - 1));
        drive_idle();
        @(negedge clock);
        check("t5_error_set", error, 1);
        send_block(3);
        wait_delivered("t5_delivered", 4, 600);
        check("t5_error_sticky", error, 1);
        check("t5_beats", beats, 4 * BEATS);
        check("t5_data", data_errs, 0);
        check("t5_done", done, 1);

        // 5b: asynchronous reset mid-block
        reset_dut(2);
        wait_reqs("t5b_reqs", 2, 100);
        send_block(0);
        drive_beat(fifo_number, 0, BEATS - 1, pat(0, BEATS - 1));
        drive_idle();
        wait_delivered("t5b_delivered", 1, 300);
        oready_mode = 0;
        send_block(1);
        wait_ovalid("t5b_ovalid", 50);
        #2;
        check("t5b_pre_error", error, 1);
        check("t5b_pre_delivered", delivered, 1);
        reset = 1'b0;
        #1;
        check("t5b_async_error", error, 0);
        check("t5b_async_ovalid", bus.o_valid, 0);
        check("t5b_async_delivered", delivered, 0);
        oready_mode = 1;

        // 6: completions for a different channel are ignored
        reset_dut(2);
        wait_reqs("t6_reqs", 2, 100);
        for (int i = 0; i < BEATS; i++) drive_beat(fifo_number + 4'd1, 0, i, pat(0, i));
        drive_idle();
        repeat (40) @(posedge clock);
        @(negedge clock);
        check("t6_beats", beats, 0);
        check("t6_ovalid", bus.o_valid, 0);
        check("t6_delivered", delivered, 0);
        check("t6_error", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hififo_fpc_reorder.md
Name: hififo_fpc_reorder

Overview:
- Parametrised successor of the from-PC reorder stage: issues read-request tags, accepts out-of-order read completions into a slot-indexed block RAM, and releases whole blocks in request order as a valid/ready stream.
- Generalised in data width, slot count, block length and outstanding limit.
- Adds a programmable transfer length, an enable gate, a done flag, sticky error detection and lossless output backpressure.
- Single clock domain; sits between the PCIe RX completion demux and a user-side FIFO or CDC stage.

Parameters:
- DBITS, 64, data width of completions and output.
- SBITS, 3, log2 of slot count (2^SBITS reorder slots).
- IBITS, 6, log2 of beats per block; block = 2^IBITS beats.
- MAX_OUT, 6, maximum outstanding requests; must be < 2^SBITS.
- HOLDOFF, 3, idle cycles enforced after each accepted request.
- CBITS, 24, width of the length and delivered-count fields.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- fifo_number  in  4  channel ID matched against rc_tag[7:4].
- enable  in  1  permits new requests.
- request_limit  in  CBITS  blocks to fetch in this transfer; 0 = no transfer.
- rc_valid  in  1  completion beat valid.
- rc_tag  in  8  completion tag: [7:4] channel, [SBITS-1:0] slot.
- rc_index  in  IBITS  beat index within the block.
- rc_data  in  DBITS  completion data.
- rr_valid  out  1  read request pending.
- rr_tag_low  out  SBITS  slot tag for the pending request.
- rr_ready  in  1  request accepted by the TX arbiter.
- o_data  out  DBITS  output data.
- o_valid  out  1  output beat valid.
- o_ready  in  1  output beat accepted.
- delivered  out  CBITS  blocks fully delivered on the output.
- done  out  1  delivered == request_limit and request_limit != 0.
- error  out  1  sticky: last beat arrived for a slot not outstanding or already filled.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All pointers, slot flags, holdoff, delivered and error clear to 0.
  - rr_valid = 0, o_valid = 0, done = 0.
  - Any in-flight output-pipeline data is discarded.
- Write path:
  - A beat is written when rc_valid is high and rc_tag[7:4] == fifo_number.
  - Write address = {rc_tag[SBITS-1:0], rc_index}.
  - Beats for other channels are ignored.
  - On the last beat (rc_index all ones), filled[slot] is set the following cycle.
- Request path:
  - rr_valid = enable && holdoff == 0 && (p_req - p_rel) < MAX_OUT && requested < request_limit.
  - rr_tag_low = p_req[SBITS-1:0].
  - A request is accepted only when rr_valid && rr_ready. On acceptance, p_req and requested increment and holdoff loads HOLDOFF.
  - Holdoff decrements to 0 and saturates there.
- Retire path:
  - p_blk advances when filled[p_blk] is set.
  - Beat pointer p_rd (SBITS+IBITS bits) reads the RAM while p_rd[top] != p_blk and the output buffer has a free entry.
  - When a block's final beat is read, filled[slot] clears and p_rel increments.
  - If set and clear hit the same slot in the same cycle, set wins.
- Output:
  - RAM read latency is 1 cycle into a 2-entry skid buffer, so no beat is lost under any o_ready pattern.
  - Minimum latency from filled[] set to first o_valid = 3 cycles.
  - Sustained throughput is 1 beat/cycle while o_ready = 1.
- Counters:
  - delivered increments when o_valid && o_ready on beat index all ones.
  - All pointers wrap modulo their widths.
  - requested and delivered saturate at request_limit.
- enable deasserted mid-transfer: no new requests are issued; outstanding completions are still accepted and drained.
- error sets when a last beat arrives for a slot whose filled flag is already set, or that is not in [p_rel, p_req). Data for such a beat is still written. error clears only on reset.
- request_limit changes are permitted only while rr_valid = 0 and delivered == requested.

Test Plan:
- request_limit=4, enable=1, completions in tag order, o_ready=1 -> 4 requests with tags 0..3, 256 beats in order, delivered=4, done=1, no further rr_valid.
- request_limit=8, completions returned in slot order 3,1,0,2 with interleaved beats -> output strictly in slot order 0,1,2,3; data matches the per-slot pattern.
- rr_ready held high continuously, no completions returned -> exactly MAX_OUT=6 requests, spaced 4 cycles apart; rr_valid stays 0 until the first block drains.
- o_ready toggling 1,0 per cycle during a 3-block stream -> no beat dropped or duplicated, throughput 50 %, delivered=3.
- Last beat sent twice for slot 2 -> error=1 sticky; normal flow continues; asserting reset low mid-block clears error, o_valid and delivered asynchronously.
- Completions tagged for fifo_number+1 -> no writes, no filled flags set, output idle.
